debounce_event_arbiter: RTL and testbench

DEBOUNCE_EVENT_ARBITER -- requirements
Module: debounce_event_arbiter

---
 rtl/debounce_event_arbiter_pkg.sv | 20 ++
 rtl/debounce_event_arbiter_rr_select.sv | 34 +++
 rtl/debounce_event_arbiter.sv | 138 +++++++++++++
 tb/tb_debounce_event_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_event_arbiter_pkg.sv
// Shared helper functions for the debounce event arbiter slice.
// Provides clog2_f and max_f, used for port and counter sizing.
package debounce_event_arbiter_pkg;

  // Ceiling log2 of value; 0 for value <= 1.
  function automatic int clog2_f(input int value);
    int result;
    result = 32'sd0;
    for (int p = 32'sd1; p < value; p = p * 32'sd2) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

  // Larger of two integers.
  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_event_arbiter_rr_select.sv
// Combinational round-robin winner search over a request vector.
// The search starts one slot past ptr and wraps modulo width. The first
// request found wins.
module event_rr_select
  import debounce_event_arbiter_pkg::*;
#(
  parameter int width       = 4,
  parameter int index_width = 2
) (
  input  logic [width-1:0]       request,
  input  logic [index_width-1:0] ptr,
  output logic                   any,
  output logic [index_width-1:0] index
);

  int slot_s;

  // Scan slots ptr+1 .. ptr+width and latch the first requesting slot.
  always_comb begin
    any    = 1'b0;
    index  = {index_width{1'b0}};
    slot_s = 32'sd0;
    for (int k = 32'sd1; k <= width; k++) begin
      slot_s = (int'(ptr) + k) % width;
      if (!any && request[slot_s]) begin
        any   = 1'b1;
        index = index_width'(slot_s);
      end else begin
        // an earlier slot already won, or this slot is idle
      end
    end
  end

endmodule

// File: rtl/debounce_event_arbiter.sv
// Debounce event arbiter: generates the shared debounce tick and turns
// per-channel level changes into a stream of (channel, level) events,
// picked round-robin and handed off with a valid/ready handshake.
// Optional feature macro: DEBOUNCE_OVERRUN_EN adds sticky per-channel
// overrun flags for changes that coalesce into an already pending event.
module debounce_event_arbiter
  import debounce_event_arbiter_pkg::*;
#(
  parameter int width    = 4,
  parameter int prescale = 1000
) (
  input  logic                                       clock,
  input  logic                                       reset,
  output logic                                       tick,
  input  logic [width-1:0]                           in,
  input  logic [width-1:0]                           in_valid,
  output logic                                       event_valid,
  input  logic                                       event_ready,
  output logic [max_f(32'sd1, clog2_f(width))-1:0]   event_channel,
  output logic                                       event_level
`ifdef DEBOUNCE_OVERRUN_EN
  ,
  output logic [width-1:0]                           overrun
`endif
);

  localparam int chan_w = max_f(32'sd1, clog2_f(width));
  localparam int cnt_w  = max_f(32'sd1, clog2_f(prescale));

  logic [cnt_w-1:0]  cnt_r;
  logic              tick_r;
  logic [width-1:0]  last_r;
  logic [width-1:0]  pending_r;
  logic [width-1:0]  change_s;
  logic [width-1:0]  grant_s;
  logic [chan_w-1:0] ptr_r;
  logic              any_s;
  logic [chan_w-1:0] winner_s;
  logic              load_s;
  logic              valid_r;
  logic [chan_w-1:0] chan_r;
  logic              level_r;

  // A channel changes only while its debouncer output is valid.
  assign change_s = in_valid & (in ^ last_r);

  // Load a new event when the output slot is empty or being accepted.
  assign load_s = any_s & (~valid_r | event_ready);

  event_rr_select #(
    .width       (width),
    .index_width (chan_w)
  ) u_rr_select (
    .request (pending_r),
    .ptr     (ptr_r),
    .any     (any_s),
    .index   (winner_s)
  );

  // One-hot mask of the pending bit consumed by this cycle's load.
  always_comb begin
    grant_s = {width{1'b0}};
    if (load_s) begin
      grant_s[winner_s] = 1'b1;
    end else begin
      grant_s = {width{1'b0}};
    end
  end

  // Prescaler counting 0..prescale-1; tick is registered so it is high
  // exactly while the count sits at prescale-1.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_r  <= {cnt_w{1'b0}};
      tick_r <= 1'b0;
    end else begin
      if (cnt_r == cnt_w'(prescale - 32'sd1)) begin
        cnt_r <= {cnt_w{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(cnt_w-1){1'b0}}, 1'b1};
      end
      tick_r <= (cnt_r == cnt_w'(prescale - 32'sd2));
    end
  end

  // Track last seen levels; a new change always re-arms pending, even in
  // the cycle its previous event is granted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_r    <= {width{1'b0}};
      pending_r <= {width{1'b0}};
    end else begin
      last_r    <= (last_r & ~change_s) | (in & change_s);
      pending_r <= (pending_r & ~grant_s) | change_s;
    end
  end

  // Output event register and round-robin pointer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_r <= 1'b0;
      chan_r  <= {chan_w{1'b0}};
      level_r <= 1'b0;
      ptr_r   <= chan_w'(width - 32'sd1);
    end else if (load_s) begin
      valid_r <= 1'b1;
      chan_r  <= winner_s;
      level_r <= last_r[winner_s];
      ptr_r   <= winner_s;
    end else if (event_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

`ifdef DEBOUNCE_OVERRUN_EN
  logic [width-1:0] overrun_r;

  // Sticky flag: a change landed on a channel whose event was still
  // waiting and not being granted, so an intermediate level was lost.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overrun_r <= {width{1'b0}};
    end else begin
      overrun_r <= overrun_r | (change_s & pending_r & ~grant_s);
    end
  end

  assign overrun = overrun_r;
`endif

  assign tick          = tick_r;
  assign event_valid   = valid_r;
  assign event_channel = chan_r;
  assign event_level   = level_r;

endmodule

// File: tb/tb_debounce_event_arbiter.sv
// Directed testbench for debounce_event_arbiter (width=4, prescale=4).
module tb_debounce_event_arbiter;

  logic       clock;
  logic       reset;
  logic       tick;
  logic [3:0] in;
  logic [3:0] in_valid;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_channel;
  logic       event_level;
`ifdef DEBOUNCE_OVERRUN_EN
  logic [3:0] overrun;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  debounce_event_arbiter #(
    .width    (4),
    .prescale (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .tick          (tick),
    .in            (in),
    .in_valid      (in_valid),
    .event_valid   (event_valid),
    .event_ready   (event_ready),
    .event_channel (event_channel),
    .event_level   (event_level)
`ifdef DEBOUNCE_OVERRUN_EN
    ,
    .overrun       (overrun)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Packed view {valid, channel, level} for compact event checks.
  function automatic logic [31:0] ev();
    return {28'd0, event_valid, event_channel, event_level};
  endfunction

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    in          = 4'b0000;
    in_valid    = 4'b0000;
    event_ready = 1'b0;
    repeat (3) step();
    check("rst_tick",    {31'd0, tick},          32'd0);
    check("rst_valid",   {31'd0, event_valid},   32'd0);
    check("rst_channel", {30'd0, event_channel}, 32'd0);
    check("rst_level",   {31'd0, event_level},   32'd0);

    // Release reset; invalid channels must stay silent whatever in is.
    in    = 4'b1111;
    reset = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      check($sformatf("tick_c%0d", e), {31'd0, tick},
            ((e == 3) || (e == 7) || (e == 11)) ? 32'd1 : 32'd0);
    end
    check("invalid_silent", {31'd0, event_valid}, 32'd0);

    // Valid level 0 after reset is not a change.
    in       = 4'b0000;
    in_valid = 4'b1111;
    repeat (3) step();
    check("valid_zero_silent", {31'd0, event_valid}, 32'd0);

    // Channels 0, 1, 3 change together: served in order on consecutive cycles.
    event_ready = 1'b1;
    in = 4'b1011;
    step();
    check("multi_lat1", {31'd0, event_valid}, 32'd0);
    step();
    check("multi_ch0", ev(), 32'b1001);
    step();
    check("multi_ch1", ev(), 32'b1011);
    step();
    check("multi_ch3", ev(), 32'b1111);
    step();
    check("multi_done", {31'd0, event_valid}, 32'd0);

    // Single change on channel 2: event two cycles later, exactly once.
    in = 4'b1111;
    step();
    check("single_lat1", {31'd0, event_valid}, 32'd0);
    step();
    check("single_ev", ev(), 32'b1101);
    step();
    check("single_once_a", {31'd0, event_valid}, 32'd0);
    step();
    check("single_once_b", {31'd0, event_valid}, 32'd0);

    // Held event on channel 3 while channel 1 toggles 1->0->1.
    event_ready = 1'b0;
    in = 4'b0111;
    step();
    in = 4'b0101;
    step();
    check("hold_first", ev(), 32'b1110);
    in = 4'b0111;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("hold_c%0d", c), ev(), 32'b1110);
    end
    event_ready = 1'b1;
    step();
    check("coalesced_ch1", ev(), 32'b1011);
    step();
    check("coalesced_once", {31'd0, event_valid}, 32'd0);

    // Reset while an event is offered and another is pending.
    event_ready = 1'b0;
    in = 4'b0010;
    step();
    step();
    check("pre_reset_ev", ev(), 32'b1100);
    reset = 1'b0;
    in    = 4'b0000;
    step();
    check("reset_valid",   {31'd0, event_valid},   32'd0);
    check("reset_pending", {28'd0, dut.pending_r}, 32'd0);
    reset       = 1'b1;
    event_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("post_reset_quiet%0d", c), {31'd0, event_valid}, 32'd0);
    end

`ifdef DEBOUNCE_OVERRUN_EN
    // Channel 0 toggles twice while its event waits behind channel 3.
    event_ready = 1'b0;
    in = 4'b1000;
    step();
    in = 4'b1001;
    step();
    check("ovr_held_ch3", ev(), 32'b1111);
    in = 4'b1000;
    step();
    in = 4'b1001;
    step();
    check("ovr_set", {28'd0, overrun}, 32'd1);
    event_ready = 1'b1;
    repeat (3) step();
    check("ovr_sticky", {28'd0, overrun}, 32'd1);
    reset = 1'b0;
    step();
    check("ovr_reset", {28'd0, overrun}, 32'd0);
    reset = 1'b1;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
